// File: rtl/adc_sample_ctrl_pkg.sv
// Shared types and constants for the SAR ADC sample controller.
package adc_sample_ctrl_pkg;

   // Sequencer states: wait for a tick, track the input, run the SAR search, store.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRACK   = 2'd1,
      CONVERT = 2'd2,
      PUSH    = 2'd3
   } state_t;

   // One SAR decision per clock, MSB first.
   localparam int SAR_CYCLES = 10;
   localparam int SAR_CNT_W  = $clog2(SAR_CYCLES);

   // Sample-period divider and track-phase counter widths.
   localparam int DIV_W = 20;
   localparam int TRK_W = 4;

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// Analog-macro and sample-FIFO signals of the ADC sample controller.
// master: the controller; slave: the analog macro plus the FIFO consumer.
interface adc_sample_ctrl_if #(
   parameter int FIFO_AW = 5,
   parameter int DW      = 10
) ();

   // Analog macro side
   logic               cmp;
   logic               EN;
   logic               SAMPLE;
   logic [DW-1:0]      dac_code;

   // Sample FIFO read side
   logic               rd;
   logic               ovf_clr;
   logic [FIFO_AW-1:0] fifo_threshold;
   logic [DW-1:0]      rdata;
   logic               empty;
   logic               full;
   logic [FIFO_AW:0]   level;
   logic               high;
   logic               ovf;

   modport master (
      input  cmp, rd, ovf_clr, fifo_threshold,
      output EN, SAMPLE, dac_code, rdata, empty, full, level, high, ovf
   );

   modport slave (
      output cmp, rd, ovf_clr, fifo_threshold,
      input  EN, SAMPLE, dac_code, rdata, empty, full, level, high, ovf
   );

endinterface

// File: rtl/adc_fifo.sv
// First-word-fall-through sample FIFO with occupancy count.
// A push on a full FIFO is accepted only when a pop frees a slot in the same
// cycle; otherwise it is reported on wr_drop and the data is discarded.
module adc_fifo #(
   parameter int DW = 10,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          wr_drop
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_q;
   logic          wr_en;
   logic          rd_en;

   assign empty   = (level_q == '0);
   assign full    = (level_q == FULL_LVL);
   assign level   = level_q;
   assign rd_en   = pop && !empty;
   assign wr_en   = push && (!full || pop);
   assign wr_drop = push && !wr_en;
   assign rdata   = mem[rd_ptr];

   // Storage write.
   // NOTE: the storage array has no reset; its contents are meaningless until written and are never read while empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally at the array depth; level tracks the net change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/adc_sample_ctrl.sv
// SAR ADC sample controller: a sample-rate divider starts a track / SAR-convert
// / store sequence, and results are queued in a FWFT FIFO with level, high and
// sticky overflow flags.
module adc_sample_ctrl
   import adc_sample_ctrl_pkg::*;
#(
   parameter int FIFO_AW = 5,
   parameter int DW      = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clk_en,
   input  logic [DIV_W-1:0]     clkdiv,
   input  logic [TRK_W-1:0]     sample_cycles,
   adc_sample_ctrl_if.master    bus
);

   localparam logic [DW-1:0]        SAR_MSB  = {1'b1, {(DW-1){1'b0}}};
   localparam logic [SAR_CNT_W-1:0] SAR_LAST = SAR_CNT_W'(SAR_CYCLES - 1);

   // Sample-rate divider
   logic [DIV_W-1:0] div_cnt_q;
   logic             tick_q;
   logic             div_run;
   logic             div_hit;

   // Sequencer
   state_t               state_q, state_d;
   logic [TRK_W-1:0]     trk_q, trk_d;
   logic [SAR_CNT_W-1:0] bit_q, bit_d;
   logic [DW-1:0]        res_q, res_d;
   logic [DW-1:0]        trial;
   logic                 sample;
   logic [DW-1:0]        dac;
   logic                 push;

   // FIFO side
   logic [DW-1:0]        fifo_rdata;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [FIFO_AW:0]     fifo_level;
   logic                 drop;
   logic                 ovf_q;

   // A count above clkdiv (clkdiv lowered on the fly) rewraps immediately.
   assign div_run = en && clk_en;
   assign div_hit = div_run && (div_cnt_q >= clkdiv);

   // Divider counts 0..clkdiv and emits a registered one-cycle tick after the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         tick_q <= div_hit;
         if (div_hit) begin
            div_cnt_q <= '0;
         end else if (div_run) begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end
      end
   end

   // Sequencer state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         trk_q   <= '0;
         bit_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         trk_q   <= trk_d;
         bit_q   <= bit_d;
         res_q   <= res_d;
      end
   end

   // Trial bit for the current SAR step, walking down from the MSB.
   assign trial = SAR_MSB >> bit_q;

   // Next-state, SAR decision and output decode.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      trk_d   = trk_q;
      bit_d   = bit_q;
      res_d   = res_q;
      sample  = 1'b0;
      dac     = '0;
      push    = 1'b0;

      case (state_q)
         IDLE: begin
            if (tick_q && en) begin
               state_d = TRACK;
               trk_d   = '0;
               bit_d   = '0;
               res_d   = '0;
            end
         end
         TRACK: begin
            sample = 1'b1;
            if (trk_q >= sample_cycles) begin
               state_d = CONVERT;
               bit_d   = '0;
            end else begin
               trk_d = trk_q + 1'b1;
            end
         end
         CONVERT: begin
            dac = res_q | trial;
            if (bus.cmp) begin
               res_d = res_q | trial;
            end
            if (bit_q == SAR_LAST) begin
               state_d = PUSH;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         PUSH: begin
            push    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Disabling abandons whatever is in flight.
      if (!en) begin
         state_d = IDLE;
         push    = 1'b0;
      end
   end

   adc_fifo #(
      .DW (DW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wdata   (res_q),
      .pop     (bus.rd),
      .rdata   (fifo_rdata),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (fifo_level),
      .wr_drop (drop)
   );

   // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign bus.EN       = en;
   assign bus.SAMPLE   = sample;
   assign bus.dac_code = dac;
   assign bus.rdata    = fifo_rdata;
   assign bus.empty    = fifo_empty;
   assign bus.full     = fifo_full;
   assign bus.level    = fifo_level;
   assign bus.high     = (fifo_level > {1'b0, bus.fifo_threshold});
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl: divider timing, SAR search, FIFO
// fill/overflow/drain, disable and reset mid-conversion.
module tb_adc_sample_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clk_en;
   logic [19:0] clkdiv;
   logic [3:0]  sample_cycles;
   logic [9:0]  vin;

   int n_pass = 0;
   int n_fail = 0;
   int n_chk  = 0;

   adc_sample_ctrl_if #(.FIFO_AW(5), .DW(10)) bus ();

   adc_sample_ctrl #(.FIFO_AW(5), .DW(10)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .clk_en        (clk_en),
      .clkdiv        (clkdiv),
      .sample_cycles (sample_cycles),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   // Ideal comparator: held input at or above the DAC trial voltage.
   assign bus.cmp = (vin >= bus.dac_code);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bounded wait for the start of a track phase.
   task automatic wait_track();
      int n = 0;
      while (bus.SAMPLE !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("track_start", bus.SAMPLE, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n              = 1'b0;
      en                 = 1'b0;
      clk_en             = 1'b0;
      clkdiv             = 20'd9;
      sample_cycles      = 4'd3;
      vin                = 10'h2A5;
      bus.rd             = 1'b0;
      bus.ovf_clr        = 1'b0;
      bus.fifo_threshold = 5'd4;

      // Reset state
      step(3);
      check("rst_empty",  bus.empty,    1);
      check("rst_full",   bus.full,     0);
      check("rst_level",  bus.level,    0);
      check("rst_ovf",    bus.ovf,      0);
      check("rst_high",   bus.high,     0);
      check("rst_sample", bus.SAMPLE,   0);
      check("rst_dac",    bus.dac_code, 0);
      check("rst_en",     bus.EN,       0);
      rst_n = 1'b1;
      step(2);

      // First sample: tick after 10 counts, 4 track cycles, 10 SAR steps, push
      en     = 1'b1;
      clk_en = 1'b1;
      check("en_follow", bus.EN, 1);
      step(10);
      check("pre_track", bus.SAMPLE, 0);
      step(1);
      check("track_first", bus.SAMPLE, 1);
      step(3);
      check("track_last", bus.SAMPLE, 1);
      step(1);
      check("conv_sample_off", bus.SAMPLE, 0);
      check("conv_trial0", bus.dac_code, 'h200);
      step(1);
      check("conv_trial1", bus.dac_code, 'h300);
      step(9);
      check("latency_empty_before", bus.empty, 1);
      step(1);
      check("latency_empty_after", bus.empty, 0);
      check("s1_level", bus.level, 1);
      check("s1_data",  bus.rdata, 'h2A5);
      check("s1_high",  bus.high,  0);

      // Full-scale input: every trial bit is kept
      vin = 10'h3FF;
      wait_track();
      step(4);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("trial_3ff_%0d", k), bus.dac_code, 'h3FF & ~((1 << (9 - k)) - 1));
         step(1);
      end
      step(1);
      check("s2_level", bus.level, 2);
      check("s2_head",  bus.rdata, 'h2A5);
      bus.rd = 1'b1;
      step(1);
      bus.rd = 1'b0;
      check("s2_pop_data",  bus.rdata, 'h3FF);
      check("s2_pop_level", bus.level, 1);

      // Zero input: every trial bit is dropped
      vin = 10'h000;
      wait_track();
      step(4);
      check("trial_000_0", bus.dac_code, 'h200);
      step(1);
      check("trial_000_1", bus.dac_code, 'h100);
      step(10);
      check("s3_level", bus.level, 2);
      bus.rd = 1'b1;
      step(1);
      check("s3_pop_data", bus.rdata, 'h000);
      step(1);
      check("drain_empty", bus.empty, 1);
      step(1);
      bus.rd = 1'b0;
      check("rd_empty_level", bus.level, 0);
      check("rd_empty_empty", bus.empty, 1);
      check("rd_empty_full",  bus.full,  0);

      // Threshold 4: high appears with the fifth stored sample
      for (int i = 0; i < 5; i++) begin
         vin = 10'h100 + 10'(i);
         wait_track();
         step(15);
         check($sformatf("thr_level_%0d", i), bus.level, i + 1);
         check($sformatf("thr_high_%0d", i),  bus.high,  (i + 1) > 4);
      end
      check("thr_head", bus.rdata, 'h100);

      // Fill to 32 entries
      for (int i = 5; i < 32; i++) begin
         vin = 10'h100 + 10'(i);
         wait_track();
         step(15);
      end
      check("fill_level", bus.level, 32);
      check("fill_full",  bus.full,  1);
      check("fill_ovf",   bus.ovf,   0);

      // Push on full is dropped and sets ovf
      vin = 10'h055;
      wait_track();
      step(15);
      check("drop_ovf",   bus.ovf,   1);
      check("drop_level", bus.level, 32);
      check("drop_head",  bus.rdata, 'h100);
      bus.ovf_clr = 1'b1;
      step(1);
      bus.ovf_clr = 1'b0;
      check("ovf_clear", bus.ovf, 0);

      // Clear coincident with a drop: the drop wins
      wait_track();
      step(14);
      bus.ovf_clr = 1'b1;
      step(1);
      bus.ovf_clr = 1'b0;
      check("drop_vs_clr", bus.ovf, 1);
      bus.ovf_clr = 1'b1;
      step(1);
      bus.ovf_clr = 1'b0;
      check("ovf_clear2", bus.ovf, 0);

      // Full FIFO, rd in the PUSH cycle: both succeed
      vin = 10'h1EE;
      wait_track();
      step(14);
      bus.rd = 1'b1;
      step(1);
      bus.rd = 1'b0;
      clk_en = 1'b0;
      check("swap_level", bus.level, 32);
      check("swap_ovf",   bus.ovf,   0);
      check("swap_head",  bus.rdata, 'h101);
      bus.rd = 1'b1;
      for (int j = 0; j < 32; j++) begin
         check($sformatf("drain_%0d", j), bus.rdata, (j < 31) ? ('h101 + j) : 'h1EE);
         step(1);
      end
      bus.rd = 1'b0;
      check("drain_level", bus.level, 0);
      check("drain_empty2", bus.empty, 1);

      // en low during SAR step 5 aborts the conversion
      clk_en = 1'b1;
      vin    = 10'h2A5;
      wait_track();
      step(9);
      check("abort_trial5", bus.dac_code, 'h2B0);
      en = 1'b0;
      step(1);
      check("abort_dac",    bus.dac_code, 0);
      check("abort_sample", bus.SAMPLE,   0);
      check("abort_en",     bus.EN,       0);
      step(5);
      check("abort_level", bus.level, 0);
      check("abort_empty", bus.empty, 1);
      en = 1'b1;

      // Reset mid-conversion discards the partial result
      wait_track();
      step(6);
      rst_n = 1'b0;
      #1;
      check("arst_dac",    bus.dac_code, 0);
      check("arst_sample", bus.SAMPLE,   0);
      check("arst_empty",  bus.empty,    1);
      check("arst_ovf",    bus.ovf,      0);
      step(2);
      rst_n = 1'b1;
      step(25);
      check("post_rst_empty", bus.empty, 1);
      step(1);
      check("post_rst_push", bus.empty, 0);
      check("post_rst_data", bus.rdata, 'h2A5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 Parameter FIFO_AW, default 5, sample FIFO address width (depth 2**FIFO_AW).
REQ-002 Parameter DW, default 10, conversion result width.
REQ-003 clk  input  1  single block clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  block enable; also drives EN output.
REQ-006 clk_en  input  1  sample-rate divider count enable.
REQ-007 clkdiv  input  20  sample period minus one, in clk cycles.
REQ-008 sample_cycles  input  4  track (sample) phase length minus one.
REQ-009 fifo_threshold  input  FIFO_AW  level threshold for high flag.
REQ-010 cmp  input  1  analog comparator; 1 = held input >= DAC trial voltage.
REQ-011 rd  input  1  pop one sample from FIFO.
REQ-012 ovf_clr  input  1  clears sticky overflow flag.
REQ-013 EN  output  1  analog macro enable, equals en.
REQ-014 SAMPLE  output  1  sample switch closed (track phase).
REQ-015 dac_code  output  DW  SAR trial code to capacitive DAC.
REQ-016 rdata  output  DW  FIFO head (first-word-fall-through).
REQ-017 empty, full  output  1 each  FIFO status.
REQ-018 level  output  FIFO_AW+1  number of stored samples.
REQ-019 high  output  1  level > fifo_threshold.
REQ-020 ovf  output  1  sticky: a result was dropped on full FIFO.

Function
REQ-021 Tick divider SHALL count 0..clkdiv while en&clk_en, wrap to 0 on match, and emit a one-cycle tick the cycle after match (period clkdiv+1).
REQ-022 FSM states SHALL be IDLE, TRACK, CONVERT, PUSH.
REQ-023 IDLE: SAMPLE=0, dac_code=0; on tick with en=1 go TRACK.
REQ-024 TRACK: SAMPLE=1 for exactly sample_cycles+1 cycles, then CONVERT.
REQ-025 CONVERT: 10 cycles, k=0..9; dac_code = committed bits | (1<<(DW-1-k)); at cycle end bit DW-1-k is kept iff cmp=1.
REQ-026 PUSH: one cycle; result written to FIFO, then IDLE.
REQ-027 Latency tick to empty=0 SHALL be sample_cycles+13 cycles.
REQ-028 Ticks outside IDLE SHALL be ignored.
REQ-029 en=0 in any state SHALL force IDLE next cycle, no push, divider counter held.
REQ-030 Push on full FIFO without simultaneous pop SHALL be dropped and set ovf.
REQ-031 Push and rd in the same cycle SHALL both succeed when full (level unchanged).
REQ-032 rd on empty SHALL be ignored; pointers, level unchanged.
REQ-033 ovf_clr SHALL clear ovf; a simultaneous drop SHALL win (ovf stays 1).
REQ-034 Pointers SHALL wrap modulo depth; level saturates never (0..2**FIFO_AW).

Reset
REQ-035 rst_n low SHALL asynchronously set: state IDLE, divider 0, tick 0, SAMPLE 0, dac_code 0, FIFO pointers 0, level 0, empty 1, full 0, ovf 0; high 0.
REQ-036 Reset mid-conversion SHALL discard the partial result.
REQ-037 FIFO storage array is not reset; rdata undefined while empty.

Structure
REQ-038 Package adc_sample_ctrl_pkg SHALL hold the FSM state encoding and the SAR cycle count (10).
REQ-039 FIFO SHALL be a sub-module adc_fifo (DW, AW parameters, level output).

Verification
REQ-040 clkdiv=9, sample_cycles=3, cmp model vin=0x2A5 -> one sample 0x2A5 every 10 cycles... period limited by FSM: tick ignored while busy; result 0x2A5, empty falls 16 cycles after tick.
REQ-041 vin=0x3FF then vin=0x000 -> results 0x3FF, 0x000; dac_code trial sequence 0x200,0x300,...,0x3FF for first.
REQ-042 Fill 32 samples, no rd -> full=1, level=32, next result dropped, ovf=1; ovf_clr -> ovf=0.
REQ-043 Full FIFO, rd coincident with PUSH -> level stays 32, ovf stays 0, new sample at tail.
REQ-044 en=0 during CONVERT cycle 5 -> IDLE next cycle, dac_code=0, level unchanged.
REQ-045 fifo_threshold=4, push 5 samples -> high rises on fifth; rd on empty -> no change.
